wsi_stream_buffer: RTL and testbench

- Parametrised WSI slave-to-master stream buffer that sits between one application worker's WSI master and the next worker's WSI slave inside a container.
- It generalises the fixed 32-bit adc/dac WSI stream ports with configurable data width, FIFO depth and ReqInfo width.
- It adds elastic buffering, SThreadBusy flow control, precise-burst length checking and message/error status counters.

---
 rtl/wsi_stream_buffer_if.sv | 31 +++
 rtl/wsi_stream_buffer.sv | 179 +++++++++++++++++
 tb/tb_wsi_stream_buffer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wsi_stream_buffer_if.sv
// WSI request/response signal bundle; master drives the request, slave drives
// SThreadBusy/SReset_n back.
`timescale 1ns/1ps
interface wsi_stream_buffer_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int BURST_WIDTH   = 12,
  parameter int REQINFO_WIDTH = 8
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [2:0]               MCmd;
  logic                     MReqLast;
  logic                     MBurstPrecise;
  logic [BURST_WIDTH-1:0]   MBurstLength;
  logic [DATA_WIDTH-1:0]    MData;
  logic [BE_WIDTH-1:0]      MByteEn;
  logic [REQINFO_WIDTH-1:0] MReqInfo;
  logic                     MReset_n;
  logic                     SThreadBusy;
  logic                     SReset_n;

  modport master (
    output MCmd, MReqLast, MBurstPrecise, MBurstLength, MData, MByteEn, MReqInfo, MReset_n,
    input  SThreadBusy, SReset_n
  );

  modport slave (
    input  MCmd, MReqLast, MBurstPrecise, MBurstLength, MData, MByteEn, MReqInfo, MReset_n,
    output SThreadBusy, SReset_n
  );
endinterface

// File: rtl/wsi_stream_buffer.sv
// Elastic WSI slave-to-master buffer with burst checking and status counters.
// Latency 1 cycle in->out; registered SThreadBusy asserted two words before full.
`timescale 1ns/1ps
module wsi_stream_buffer #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 16,
  parameter int BURST_WIDTH   = 12,
  parameter int REQINFO_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  wsi_stream_buffer_if.slave        wsi_s,
  wsi_stream_buffer_if.master       wsi_m,
  output logic [31:0]               msg_count,
  output logic [$clog2(DEPTH):0]    fill,
  output logic                      overflow_err,
  output logic                      burst_err,
  input  logic                      clear_err
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int AW       = $clog2(DEPTH);
  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_WRITE = 3'b001;

  typedef logic [AW:0] fill_t;
  localparam fill_t FULL     = fill_t'(DEPTH);
  localparam fill_t BUSY_LVL = fill_t'(DEPTH - 2);

  typedef struct packed {
    logic                     reqLast;
    logic                     burstPrecise;
    logic [BURST_WIDTH-1:0]   burstLength;
    logic [DATA_WIDTH-1:0]    data;
    logic [BE_WIDTH-1:0]      byteEn;
    logic [REQINFO_WIDTH-1:0] reqInfo;
  } word_t;

  typedef enum logic {S_IDLE, S_IN_MSG} state_t;

  word_t                  mem [DEPTH];
  word_t                  inWord;
  word_t                  head;
  logic [AW-1:0]          wrPtr;
  logic [AW-1:0]          rdPtr;
  fill_t                  fillNext;
  logic                   dnAlive;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   drop;
  state_t                 state;
  logic [BURST_WIDTH-1:0] len;
  logic [BURST_WIDTH-1:0] cnt;
  logic [BURST_WIDTH-1:0] cntInc;
  logic                   prec;

  assign inWord = '{reqLast:      wsi_s.MReqLast,
                    burstPrecise: wsi_s.MBurstPrecise,
                    burstLength:  wsi_s.MBurstLength,
                    data:         wsi_s.MData,
                    byteEn:       wsi_s.MByteEn,
                    reqInfo:      wsi_s.MReqInfo};
  assign head    = mem[rdPtr];
  assign dnAlive = wsi_m.SReset_n;

  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign accept = !RST && (wsi_s.MCmd == CMD_WRITE) && wsi_s.MReset_n;
  assign pop    = !RST && dnAlive && !wsi_m.SThreadBusy && (fill != '0);
  assign push   = accept && dnAlive && ((fill < FULL) || pop);
  assign drop   = accept && dnAlive && !push;
  assign cntInc = (cnt == '1) ? cnt : cnt + BURST_WIDTH'(1);

  always_comb begin
    fillNext = fill;
    if (!dnAlive) begin
      fillNext = '0;
    end else if (push && !pop) begin
      fillNext = fill + fill_t'(1);
    end else if (pop && !push) begin
      fillNext = fill - fill_t'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wrPtr] <= inWord;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wrPtr             <= '0;
      rdPtr             <= '0;
      fill              <= '0;
      msg_count         <= '0;
      overflow_err      <= 1'b0;
      wsi_s.SThreadBusy <= 1'b1;
      wsi_s.SReset_n    <= 1'b0;
      wsi_m.MReset_n    <= 1'b0;
    end else begin
      wsi_s.SReset_n    <= 1'b1;
      wsi_m.MReset_n    <= 1'b1;
      fill              <= fillNext;
      wsi_s.SThreadBusy <= (fillNext >= BUSY_LVL);
      if (!dnAlive) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + AW'(1);
        if (pop)  rdPtr <= rdPtr + AW'(1);
      end
      if (pop && head.reqLast) begin
        msg_count <= msg_count + 32'd1;
      end
      if (clear_err) overflow_err <= 1'b0;
      if (drop)      overflow_err <= 1'b1;
    end
  end

  // Framing tracker: a set in the same cycle as clear_err wins by ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      len       <= '0;
      cnt       <= '0;
      prec      <= 1'b0;
      burst_err <= 1'b0;
    end else begin
      if (clear_err) burst_err <= 1'b0;
      if (!dnAlive || !wsi_s.MReset_n) begin
        state <= S_IDLE;
      end else if (push) begin
        case (state)
          S_IDLE: begin
            if (inWord.reqLast) begin
              if (inWord.burstPrecise && (inWord.burstLength != BURST_WIDTH'(1))) begin
                burst_err <= 1'b1;
              end
            end else begin
              len   <= inWord.burstLength;
              prec  <= inWord.burstPrecise;
              cnt   <= BURST_WIDTH'(1);
              state <= S_IN_MSG;
            end
          end
          S_IN_MSG: begin
            cnt <= cntInc;
            if (inWord.reqLast) begin
              if (prec && (cntInc != len)) burst_err <= 1'b1;
              state <= S_IDLE;
            end else if (prec && (cntInc == len)) begin
              burst_err <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    wsi_m.MCmd          = CMD_IDLE;
    wsi_m.MReqLast      = 1'b0;
    wsi_m.MBurstPrecise = 1'b0;
    wsi_m.MBurstLength  = '0;
    wsi_m.MData         = '0;
    wsi_m.MByteEn       = '0;
    wsi_m.MReqInfo      = '0;
    if (pop) begin
      wsi_m.MCmd          = CMD_WRITE;
      wsi_m.MReqLast      = head.reqLast;
      wsi_m.MBurstPrecise = head.burstPrecise;
      wsi_m.MBurstLength  = head.burstLength;
      wsi_m.MData         = head.data;
      wsi_m.MByteEn       = head.byteEn;
      wsi_m.MReqInfo      = head.reqInfo;
    end
  end
endmodule

// File: tb/tb_wsi_stream_buffer.sv
// Scoreboard bench for wsi_stream_buffer: expected words queued at drive time,
// popped and compared whenever the DUT emits a WRITE downstream.
`timescale 1ns/1ps
module tb_wsi_stream_buffer;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int BW = 12;
  localparam int RW = 8;
  localparam logic [2:0] IDLE = 3'b000;
  localparam logic [2:0] WR   = 3'b001;

  logic        CLK = 1'b0;
  logic        RST;
  logic        clear_err;
  logic [31:0] msg_count;
  logic [4:0]  fill;
  logic        overflow_err;
  logic        burst_err;

  wsi_stream_buffer_if #(.DATA_WIDTH(DW), .BURST_WIDTH(BW), .REQINFO_WIDTH(RW)) wsiS ();
  wsi_stream_buffer_if #(.DATA_WIDTH(DW), .BURST_WIDTH(BW), .REQINFO_WIDTH(RW)) wsiM ();

  wsi_stream_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BURST_WIDTH(BW), .REQINFO_WIDTH(RW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .wsi_s        (wsiS),
    .wsi_m        (wsiM),
    .msg_count    (msg_count),
    .fill         (fill),
    .overflow_err (overflow_err),
    .burst_err    (burst_err),
    .clear_err    (clear_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
    logic [7:0]  info;
    logic        last;
    logic        prec;
    logic [11:0] len;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nOut = 0;
  int   expMsg = 0;
  bit   chkLat = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic setUp(input logic [2:0] cmd, input logic [31:0] d, input logic last,
                       input logic prec, input logic [11:0] len);
    wsiS.MCmd          = cmd;
    wsiS.MData         = d;
    wsiS.MByteEn       = d[3:0];
    wsiS.MReqInfo      = d[15:8];
    wsiS.MReqLast      = last;
    wsiS.MBurstPrecise = prec;
    wsiS.MBurstLength  = len;
  endtask

  task automatic sendWord(input logic [31:0] d, input logic last, input logic prec,
                          input logic [11:0] len, input bit keep);
    @(posedge CLK); #1;
    setUp(WR, d, last, prec, len);
    if (keep) sbq.push_back('{data: d, be: d[3:0], info: d[15:8], last: last,
                              prec: prec, len: len, cyc: cyc});
  endtask

  task automatic upIdle();
    @(posedge CLK); #1;
    setUp(IDLE, 32'd0, 1'b0, 1'b0, 12'd0);
  endtask

  task automatic pulseClear();
    @(posedge CLK); #1; clear_err = 1'b1;
    @(posedge CLK); #1; clear_err = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sbq.size() != 0; k++) @(negedge CLK);
    repeat (2) @(negedge CLK);
  endtask

  task automatic monitor();
    exp_t e;
    logic [57:0] got, want;
    forever begin
      @(negedge CLK);
      if (wsiM.MCmd === WR) begin
        nOut++;
        checks++;
        got = {wsiM.MData, wsiM.MByteEn, wsiM.MReqInfo, wsiM.MReqLast,
               wsiM.MBurstPrecise, wsiM.MBurstLength};
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got word %h with empty scoreboard", got);
        end else begin
          e = sbq.pop_front();
          want = {e.data, e.be, e.info, e.last, e.prec, e.len};
          if (got !== want) begin
            errors++;
            $display("FAIL sb_word got %h expected %h", got, want);
          end
          if (chkLat) begin
            checks++;
            if (cyc !== e.cyc + 1) begin
              errors++;
              $display("FAIL sb_latency got cycle %0d expected %0d", cyc, e.cyc + 1);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    clear_err = 1'b0;
    wsiS.MReset_n = 1'b1;
    wsiM.SThreadBusy = 1'b0;
    wsiM.SReset_n = 1'b1;
    setUp(WR, 32'hDEAD_BEEF, 1'b1, 1'b0, 12'd1);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL reset_fill got %0d expected 0", fill); end
    checks++; if (wsiM.MCmd !== IDLE) begin errors++; $display("FAIL reset_mcmd got %0d expected 0", wsiM.MCmd); end
    checks++; if (wsiM.MData !== 32'd0) begin errors++; $display("FAIL reset_mdata got %h expected 0", wsiM.MData); end
    checks++; if (wsiS.SThreadBusy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b expected 1", wsiS.SThreadBusy); end
    checks++; if (wsiS.SReset_n !== 1'b0) begin errors++; $display("FAIL reset_sreset got %b expected 0", wsiS.SReset_n); end
    checks++; if (wsiM.MReset_n !== 1'b0) begin errors++; $display("FAIL reset_mreset got %b expected 0", wsiM.MReset_n); end
    checks++; if ({msg_count, overflow_err, burst_err} !== 34'd0) begin errors++; $display("FAIL reset_status got %0d/%b/%b expected 0/0/0", msg_count, overflow_err, burst_err); end
    @(posedge CLK); #1;
    RST = 1'b0;
    setUp(IDLE, 32'd0, 1'b0, 1'b0, 12'd0);
    @(negedge CLK);
    checks++; if (wsiS.SReset_n !== 1'b0) begin errors++; $display("FAIL release_early got %b expected 0", wsiS.SReset_n); end
    @(negedge CLK);
    checks++; if ({wsiS.SReset_n, wsiM.MReset_n} !== 2'b11) begin errors++; $display("FAIL release_resets got %b expected 11", {wsiS.SReset_n, wsiM.MReset_n}); end
    checks++; if ({wsiS.SThreadBusy, fill} !== 6'd0) begin errors++; $display("FAIL release_busy_fill got %b/%0d expected 0/0", wsiS.SThreadBusy, fill); end
  endtask

  task automatic test_streaming();
    int base = nOut;
    chkLat = 1'b1;
    for (int i = 0; i < 64; i++) sendWord(32'hA500_0000 + i, i == 63, 1'b1, 12'd64, 1'b1);
    upIdle();
    drain();
    chkLat = 1'b0;
    expMsg++;
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL stream_drain got %0d left expected 0", sbq.size()); end
    checks++; if (nOut - base != 64) begin errors++; $display("FAIL stream_count got %0d expected 64", nOut - base); end
    checks++; if (msg_count !== expMsg) begin errors++; $display("FAIL stream_msgs got %0d expected %0d", msg_count, expMsg); end
    checks++; if (burst_err !== 1'b0) begin errors++; $display("FAIL stream_burst_err got %b expected 0", burst_err); end
  endtask

  task automatic test_backpressure();
    int base = nOut;
    int nSent = 0;
    int maxFill = 0;
    int busyFill = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK); #1;
      wsiM.SThreadBusy = 1'b1;
      if (wsiS.SThreadBusy === 1'b0) begin
        setUp(WR, 32'hBB00_0000 + k, 1'b1, 1'b0, 12'd1);
        sbq.push_back('{data: 32'hBB00_0000 + k, be: 4'(k), info: 8'd0, last: 1'b1,
                        prec: 1'b0, len: 12'd1, cyc: cyc});
        nSent++;
      end else begin
        setUp(IDLE, 32'd0, 1'b0, 1'b0, 12'd0);
      end
      @(negedge CLK);
      if (int'(fill) > maxFill) maxFill = int'(fill);
      if (wsiS.SThreadBusy === 1'b1 && busyFill < 0) busyFill = int'(fill);
    end
    @(posedge CLK); #1;
    setUp(IDLE, 32'd0, 1'b0, 1'b0, 12'd0);
    wsiM.SThreadBusy = 1'b0;
    drain();
    expMsg += nSent;
    checks++; if (busyFill != DEPTH - 2) begin errors++; $display("FAIL bp_busy_level got fill %0d expected %0d", busyFill, DEPTH - 2); end
    checks++; if (maxFill > DEPTH - 1) begin errors++; $display("FAIL bp_peak got %0d expected <= %0d", maxFill, DEPTH - 1); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL bp_overflow got %b expected 0", overflow_err); end
    checks++; if (nOut - base != nSent) begin errors++; $display("FAIL bp_delivered got %0d expected %0d", nOut - base, nSent); end
    checks++; if (msg_count !== expMsg) begin errors++; $display("FAIL bp_msgs got %0d expected %0d", msg_count, expMsg); end
  endtask

  task automatic test_overflow();
    int base = nOut;
    @(posedge CLK); #1; wsiM.SThreadBusy = 1'b1;
    for (int i = 0; i < 18; i++) sendWord(32'hC000_0000 + i, 1'b1, 1'b0, 12'd1, i < DEPTH);
    upIdle();
    @(negedge CLK);
    checks++; if (fill !== 5'd16) begin errors++; $display("FAIL ovf_fill got %0d expected 16", fill); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b expected 1", overflow_err); end
    pulseClear();
    @(negedge CLK);
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b expected 0", overflow_err); end
    // drop and clear in the same cycle: the set must win
    @(posedge CLK); #1;
    setUp(WR, 32'hC0DE_0000, 1'b1, 1'b0, 12'd1);
    clear_err = 1'b1;
    @(posedge CLK); #1;
    clear_err = 1'b0;
    setUp(IDLE, 32'd0, 1'b0, 1'b0, 12'd0);
    @(negedge CLK);
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b expected 1", overflow_err); end
    pulseClear();
    @(posedge CLK); #1; wsiM.SThreadBusy = 1'b0;
    drain();
    expMsg += DEPTH;
    checks++; if (nOut - base != DEPTH) begin errors++; $display("FAIL ovf_delivered got %0d expected %0d", nOut - base, DEPTH); end
    checks++; if (msg_count !== expMsg) begin errors++; $display("FAIL ovf_msgs got %0d expected %0d", msg_count, expMsg); end
  endtask

  int  bmWords[6] = '{3, 4, 1, 1, 3, 5};
  int  bmLen[6]   = '{4, 4, 3, 1, 2, 5};
  bit  bmErr[6]   = '{1, 0, 1, 0, 1, 0};

  task automatic test_burst_mismatch();
    for (int t = 0; t < 6; t++) begin
      pulseClear();
      for (int w = 0; w < bmWords[t]; w++)
        sendWord(32'hB000_0000 + 32'(t * 16 + w), w == bmWords[t] - 1, 1'b1, 12'(bmLen[t]), 1'b1);
      upIdle();
      @(negedge CLK);
      expMsg++;
      checks++;
      if (burst_err !== bmErr[t]) begin
        errors++;
        $display("FAIL burst_case%0d got %b expected %b", t, burst_err, bmErr[t]);
      end
    end
    drain();
    checks++; if (msg_count !== expMsg) begin errors++; $display("FAIL burst_msgs got %0d expected %0d", msg_count, expMsg); end
  endtask

  task automatic test_dn_reset();
    pulseClear();
    @(posedge CLK); #1; wsiM.SThreadBusy = 1'b1;
    for (int i = 0; i < 10; i++) sendWord(32'hD000_0000 + i, 1'b0, 1'b1, 12'd20, 1'b0);
    upIdle();
    @(negedge CLK);
    checks++; if (fill !== 5'd10) begin errors++; $display("FAIL dnr_buffered got %0d expected 10", fill); end
    @(posedge CLK); #1; wsiM.SReset_n = 1'b0;
    @(posedge CLK); #1; wsiM.SReset_n = 1'b1; wsiM.SThreadBusy = 1'b0;
    @(negedge CLK);
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL dnr_flush got %0d expected 0", fill); end
    checks++; if (msg_count !== expMsg) begin errors++; $display("FAIL dnr_msgs got %0d expected %0d", msg_count, expMsg); end
    checks++; if (wsiS.SThreadBusy !== 1'b0) begin errors++; $display("FAIL dnr_busy got %b expected 0", wsiS.SThreadBusy); end
    for (int i = 0; i < 3; i++) sendWord(32'hE000_0000 + i, i == 2, 1'b1, 12'd3, 1'b1);
    upIdle();
    drain();
    expMsg++;
    checks++; if (burst_err !== 1'b0) begin errors++; $display("FAIL dnr_burst_err got %b expected 0", burst_err); end
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL dnr_drain got %0d left expected 0", sbq.size()); end
    checks++; if (msg_count !== expMsg) begin errors++; $display("FAIL dnr_after_msgs got %0d expected %0d", msg_count, expMsg); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_streaming();
    test_backpressure();
    test_overflow();
    test_burst_mismatch();
    test_dn_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
